// File: rtl/multi_ch_txn_fragmenter.sv
// Multi-channel VLSU request fragmenter: per-channel FIFOs, round-robin grant, boundary-safe bus split.
// Strided mode is built only when TXN_FRAG_STRIDED_EN is defined; otherwise every request is unit stride.
module multi_ch_txn_fragmenter #(
    parameter int unsigned NrCh        = 2,
    parameter int unsigned ReqDepth    = 2,
    parameter int unsigned AddrW       = 64,
    parameter int unsigned LenW        = 16,
    parameter int unsigned IdW         = 4,
    parameter int unsigned MaxTxnBytes = 256,
    localparam int unsigned ChW        = (NrCh > 1) ? $clog2(NrCh) : 1,
    localparam int unsigned BytesW     = $clog2(MaxTxnBytes) + 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NrCh-1:0]            req_valid_i,
    output logic [NrCh-1:0]            req_ready_o,
    input  logic [NrCh-1:0][AddrW-1:0] req_addr_i,
    input  logic [NrCh-1:0][LenW-1:0]  req_nelem_i,
    input  logic [NrCh-1:0][1:0]       req_sew_i,
    input  logic [NrCh-1:0]            req_strd_i,
    input  logic [NrCh-1:0][AddrW-1:0] req_stride_i,
    input  logic [NrCh-1:0][IdW-1:0]   req_id_i,
    input  logic [NrCh-1:0]            stall_i,
    input  logic                       meta_full_i,
    output logic                       meta_enq_o,
    output logic                       txn_valid_o,
    input  logic                       txn_ready_i,
    output logic [AddrW-1:0]           txn_addr_o,
    output logic [BytesW-1:0]          txn_bytes_o,
    output logic [ChW-1:0]             txn_ch_o,
    output logic [IdW-1:0]             txn_id_o,
    output logic                       txn_last_seg_o,
    output logic                       txn_last_o,
    output logic [1:0]                 state_o
);

    localparam int unsigned OffW = $clog2(MaxTxnBytes);
    localparam int unsigned PtrW = $clog2(ReqDepth);
    localparam int unsigned RemW = LenW + 3;

    typedef struct packed {
`ifdef TXN_FRAG_STRIDED_EN
        logic             strd;
        logic [AddrW-1:0] stride;
`endif
        logic [AddrW-1:0] addr;
        logic [LenW-1:0]  nelem;
        logic [1:0]       sew;
        logic [IdW-1:0]   id;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        STALL = 2'd2,
        FRAG  = 2'd3
    } state_e;

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
    // txn_valid_o and all txn_* fields stay put until that transfer happens.
    state_e           state_q, state_d;
    logic             rdy_en_q;
    logic [NrCh-1:0]  fifo_empty;
    logic [NrCh-1:0]  push;
    logic [NrCh-1:0]  pop;
    req_t             head [NrCh];

`ifndef TXN_FRAG_STRIDED_EN
    logic unused_strided;
    assign unused_strided = ^{req_strd_i, req_stride_i};
`endif

    for (genvar c = 0; c < NrCh; c++) begin : g_fifo
        req_t            mem [ReqDepth];
        req_t            wdata;
        logic [PtrW-1:0] wr_q, rd_q;
        logic [PtrW:0]   cnt_q;

        always_comb begin
            wdata       = '0;
            wdata.addr  = req_addr_i[c];
            wdata.nelem = req_nelem_i[c];
            wdata.sew   = req_sew_i[c];
            wdata.id    = req_id_i[c];
`ifdef TXN_FRAG_STRIDED_EN
            wdata.strd   = req_strd_i[c];
            wdata.stride = req_stride_i[c];
`endif
        end

        // A full FIFO still accepts a push in the cycle its head is granted.
        assign fifo_empty[c]  = (cnt_q == '0);
        assign req_ready_o[c] = rdy_en_q && ((cnt_q != (PtrW+1)'(ReqDepth)) || pop[c]);
        assign push[c]        = req_valid_i[c] && req_ready_o[c];
        assign head[c]        = mem[rd_q];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push[c]) wr_q <= wr_q + 1'b1;
                if (pop[c])  rd_q <= rd_q + 1'b1;
                cnt_q <= cnt_q + (PtrW+1)'(push[c]) - (PtrW+1)'(pop[c]);
            end
        end

        always_ff @(posedge clk_i) begin
            if (push[c]) mem[wr_q] <= wdata;
        end
    end

    logic [NrCh-1:0] cand;
    logic            gnt_valid;
    logic [ChW-1:0]  gnt_ch, rr_q, rr_nxt;
    req_t            gnt_req;

    assign cand = ~fifo_empty & ~stall_i;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        for (int i = 0; i < int'(NrCh); i++) begin
            if (!gnt_valid && cand[(int'(rr_q) + i) % int'(NrCh)]) begin
                gnt_valid = 1'b1;
                gnt_ch    = ChW'((int'(rr_q) + i) % int'(NrCh));
            end
        end
    end

    assign gnt_req = head[gnt_ch];
    assign rr_nxt  = (int'(gnt_ch) == int'(NrCh) - 1) ? '0 : gnt_ch + 1'b1;
    assign pop     = (state_q == IDLE && gnt_valid) ? (NrCh'(1) << gnt_ch) : '0;

    logic [ChW-1:0]   r_ch;
    logic [AddrW-1:0] r_addr;
    logic [LenW-1:0]  r_nelem;
    logic [1:0]       r_sew;
    logic [IdW-1:0]   r_id;
    logic [AddrW-1:0] cur_addr_q;
    logic [RemW-1:0]  rem_q;
    logic             first_q;
`ifdef TXN_FRAG_STRIDED_EN
    logic             r_strd;
    logic [AddrW-1:0] r_stride;
    logic [AddrW-1:0] seg_base_q;
    logic [LenW-1:0]  seg_left_q;
`endif

    logic [RemW-1:0] elem_bytes, unit_len, txn_len;
    logic [OffW:0]   room;
    logic            last_seg, last_txn, hs, ch_hold;

    assign elem_bytes = RemW'(1) << r_sew;
    assign unit_len   = RemW'(r_nelem) << r_sew;
    // Bytes left before the next MaxTxnBytes-aligned boundary.
    assign room       = (OffW+1)'(MaxTxnBytes) - (OffW+1)'(cur_addr_q[OffW-1:0]);
    assign txn_len    = (rem_q < RemW'(room)) ? rem_q : RemW'(room);
    assign last_seg   = (txn_len == rem_q);
`ifdef TXN_FRAG_STRIDED_EN
    assign last_txn   = last_seg && (seg_left_q == '0);
`else
    assign last_txn   = last_seg;
`endif
    assign hs         = (state_q == FRAG) && txn_ready_i;
    assign ch_hold    = stall_i[r_ch] || meta_full_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (gnt_valid && gnt_req.nelem != '0) state_d = INIT;
            INIT:  state_d = ch_hold ? STALL : FRAG;
            STALL: if (!ch_hold) state_d = FRAG;
            FRAG:  if (hs && last_txn) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_en_q   <= 1'b0;
            first_q    <= 1'b0;
            rr_q       <= '0;
            r_ch       <= '0;
            r_addr     <= '0;
            r_nelem    <= '0;
            r_sew      <= '0;
            r_id       <= '0;
            cur_addr_q <= '0;
            rem_q      <= '0;
`ifdef TXN_FRAG_STRIDED_EN
            r_strd     <= 1'b0;
            r_stride   <= '0;
            seg_base_q <= '0;
            seg_left_q <= '0;
`endif
        end else begin
            rdy_en_q <= 1'b1;
            first_q  <= (state_d == FRAG) && (state_q != FRAG);
            if (state_q == IDLE && gnt_valid) begin
                rr_q    <= rr_nxt;
                r_ch    <= gnt_ch;
                r_addr  <= gnt_req.addr;
                r_nelem <= gnt_req.nelem;
                r_sew   <= gnt_req.sew;
                r_id    <= gnt_req.id;
`ifdef TXN_FRAG_STRIDED_EN
                r_strd   <= gnt_req.strd;
                r_stride <= gnt_req.stride;
`endif
            end
            if (state_q == INIT) begin
                cur_addr_q <= r_addr;
`ifdef TXN_FRAG_STRIDED_EN
                rem_q      <= r_strd ? elem_bytes : unit_len;
                seg_base_q <= r_addr;
                seg_left_q <= r_strd ? r_nelem - 1'b1 : '0;
`else
                rem_q      <= unit_len;
`endif
            end
            if (hs) begin
                if (!last_seg) begin
                    cur_addr_q <= cur_addr_q + AddrW'(txn_len);
                    rem_q      <= rem_q - txn_len;
                end
`ifdef TXN_FRAG_STRIDED_EN
                else if (!last_txn) begin
                    seg_base_q <= seg_base_q + r_stride;
                    cur_addr_q <= seg_base_q + r_stride;
                    rem_q      <= elem_bytes;
                    seg_left_q <= seg_left_q - 1'b1;
                end
`endif
            end
        end
    end

    assign txn_valid_o    = (state_q == FRAG);
    assign txn_addr_o     = cur_addr_q;
    assign txn_bytes_o    = txn_len[BytesW-1:0];
    assign txn_ch_o       = r_ch;
    assign txn_id_o       = r_id;
    assign txn_last_seg_o = txn_valid_o && last_seg;
    assign txn_last_o     = txn_valid_o && last_txn;
    assign meta_enq_o     = txn_valid_o && first_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_multi_ch_txn_fragmenter.sv
// Directed bench for multi_ch_txn_fragmenter; strided expectations follow TXN_FRAG_STRIDED_EN.
module tb_multi_ch_txn_fragmenter;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [1:0]       req_valid_i;
    logic [1:0]       req_ready_o;
    logic [1:0][63:0] req_addr_i;
    logic [1:0][15:0] req_nelem_i;
    logic [1:0][1:0]  req_sew_i;
    logic [1:0]       req_strd_i;
    logic [1:0][63:0] req_stride_i;
    logic [1:0][3:0]  req_id_i;
    logic [1:0]       stall_i;
    logic             meta_full_i;
    logic             meta_enq_o;
    logic             txn_valid_o;
    logic             txn_ready_i;
    logic [63:0]      txn_addr_o;
    logic [8:0]       txn_bytes_o;
    logic [0:0]       txn_ch_o;
    logic [3:0]       txn_id_o;
    logic             txn_last_seg_o;
    logic             txn_last_o;
    logic [1:0]       state_o;

    multi_ch_txn_fragmenter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_nelem_i(req_nelem_i), .req_sew_i(req_sew_i),
        .req_strd_i(req_strd_i), .req_stride_i(req_stride_i), .req_id_i(req_id_i),
        .stall_i(stall_i), .meta_full_i(meta_full_i), .meta_enq_o(meta_enq_o),
        .txn_valid_o(txn_valid_o), .txn_ready_i(txn_ready_i),
        .txn_addr_o(txn_addr_o), .txn_bytes_o(txn_bytes_o), .txn_ch_o(txn_ch_o),
        .txn_id_o(txn_id_o), .txn_last_seg_o(txn_last_seg_o), .txn_last_o(txn_last_o),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int meta_cnt = 0;
    logic [79:0] exp_q[$];
    logic [79:0] mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_txn(input logic [63:0] a, input int b, input int ch, input int id,
                              input logic ls, input logic l);
        exp_q.push_back({a, 9'(b), 1'(ch), 4'(id), ls, l});
    endtask

    // driver tasks
    task automatic drive_req(input int ch, input logic [63:0] addr, input logic [15:0] nelem,
                             input logic [1:0] sew, input logic strd, input logic [63:0] stride,
                             input logic [3:0] id);
        req_addr_i[ch]   = addr;
        req_nelem_i[ch]  = nelem;
        req_sew_i[ch]    = sew;
        req_strd_i[ch]   = strd;
        req_stride_i[ch] = stride;
        req_id_i[ch]     = id;
        req_valid_i[ch]  = 1'b1;
        check("req_ready", req_ready_o[ch], 1'b1);
    endtask

    task automatic push(input int ch, input logic [63:0] addr, input logic [15:0] nelem,
                        input logic [1:0] sew, input logic strd, input logic [63:0] stride,
                        input logic [3:0] id);
        drive_req(ch, addr, nelem, sew, strd, stride, id);
        tick();
        req_valid_i = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || state_o != 2'd0); i++) tick();
        check(tag, 64'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // scoreboard: every accepted transaction must match the head of exp_q
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (meta_enq_o) meta_cnt++;
            if (txn_valid_o && txn_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("txn_unexpected", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("txn_addr", txn_addr_o, mon_e[79:16]);
                    check("txn_bytes", 64'(txn_bytes_o), 64'(mon_e[15:7]));
                    check("txn_ch", 64'(txn_ch_o), 64'(mon_e[6]));
                    check("txn_id", 64'(txn_id_o), 64'(mon_e[5:2]));
                    check("txn_last_seg", 64'(txn_last_seg_o), 64'(mon_e[1]));
                    check("txn_last", 64'(txn_last_o), 64'(mon_e[0]));
                end
            end
        end
    end

    initial begin
        #500000;
        check("global_timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    int m0;

    initial begin
        rst_ni = 1'b0;
        req_valid_i = '0; req_addr_i = '0; req_nelem_i = '0; req_sew_i = '0;
        req_strd_i = '0; req_stride_i = '0; req_id_i = '0;
        stall_i = '0; meta_full_i = 1'b0; txn_ready_i = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_valid", txn_valid_o, 0);
        check("rst_meta", meta_enq_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_addr", txn_addr_o, 0);
        check("rst_last", {txn_last_seg_o, txn_last_o}, 0);
        rst_ni = 1'b1;
        check("ready_before_edge", req_ready_o, 0);
        tick();
        check("ready_after_edge", req_ready_o, 2'b11);
        check("rst_state", state_o, 0);

        // unit stride with cycle-accurate latency
        txn_ready_i = 1'b1;
        m0 = meta_cnt;
        expect_txn(64'h1F0, 16, 0, 3, 1'b0, 1'b0);
        expect_txn(64'h200, 144, 0, 3, 1'b1, 1'b1);
        push(0, 64'h1F0, 16'd40, 2'd2, 1'b0, 64'h0, 4'd3);
        check("unit_c1_valid", txn_valid_o, 0);
        tick();
        check("unit_c2_state", state_o, 2'd1);
        tick();
        check("unit_c3_valid", txn_valid_o, 1);
        check("unit_c3_meta", meta_enq_o, 1);
        drain("unit_drain");
        check("unit_meta_cnt", 64'(meta_cnt - m0), 1);

        // strided request (unit stride when the strided build is off)
        m0 = meta_cnt;
`ifdef TXN_FRAG_STRIDED_EN
        expect_txn(64'h100, 8, 1, 5, 1'b1, 1'b0);
        expect_txn(64'h1100, 8, 1, 5, 1'b1, 1'b0);
        expect_txn(64'h2100, 8, 1, 5, 1'b1, 1'b1);
`else
        expect_txn(64'h100, 24, 1, 5, 1'b1, 1'b1);
`endif
        push(1, 64'h100, 16'd3, 2'd3, 1'b1, 64'h1000, 4'd5);
        drain("strd_drain");
        check("strd_meta_cnt", 64'(meta_cnt - m0), 1);

        // element crossing an aligned boundary, with meta_full holding it in STALL
        meta_full_i = 1'b1;
        expect_txn(64'hFC, 4, 0, 7, 1'b0, 1'b0);
        expect_txn(64'h100, 4, 0, 7, 1'b1, 1'b1);
        push(0, 64'hFC, 16'd1, 2'd3, 1'b1, 64'h40, 4'd7);
        repeat (2) tick();
        check("metafull_state", state_o, 2'd2);
        check("metafull_valid", txn_valid_o, 0);
        meta_full_i = 1'b0;
        drain("bound_drain");

        // arbitration from pointer 0
        do_reset();
        txn_ready_i = 1'b0;
        m0 = meta_cnt;
        expect_txn(64'h0, 4, 0, 1, 1'b1, 1'b1);
        expect_txn(64'h1000, 16, 1, 2, 1'b1, 1'b1);
        expect_txn(64'h2000, 1, 0, 3, 1'b1, 1'b1);
        drive_req(0, 64'h0, 16'd4, 2'd0, 1'b0, 64'h0, 4'd1);
        drive_req(1, 64'h1000, 16'd2, 2'd3, 1'b0, 64'h0, 4'd2);
        tick();
        req_valid_i = '0;
        push(0, 64'h2000, 16'd1, 2'd0, 1'b0, 64'h0, 4'd3);
        repeat (2) tick();
        check("arb_first_ch", 64'(txn_ch_o), 0);
        txn_ready_i = 1'b1;
        drain("arb_drain");
        check("arb_meta_cnt", 64'(meta_cnt - m0), 3);

        // stall then backpressure
        txn_ready_i = 1'b0;
        m0 = meta_cnt;
        push(0, 64'h1F0, 16'd40, 2'd2, 1'b0, 64'h0, 4'd4);
        tick();
        check("stall_init", state_o, 2'd1);
        stall_i[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_state", state_o, 2'd2);
            check("stall_valid", txn_valid_o, 0);
        end
        stall_i[0] = 1'b0;
        tick();
        check("stall_frag_valid", txn_valid_o, 1);
        check("stall_frag_meta", meta_enq_o, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", txn_valid_o, 1);
            check("bp_addr", txn_addr_o, 64'h1F0);
            check("bp_bytes", 64'(txn_bytes_o), 16);
            check("bp_meta", meta_enq_o, 0);
        end
        expect_txn(64'h1F0, 16, 0, 4, 1'b0, 1'b0);
        expect_txn(64'h200, 144, 0, 4, 1'b1, 1'b1);
        txn_ready_i = 1'b1;
        drain("bp_drain");
        check("bp_meta_cnt", 64'(meta_cnt - m0), 1);

        // zero-length request is dropped, next one still flows
        m0 = meta_cnt;
        push(1, 64'h500, 16'd0, 2'd2, 1'b0, 64'h0, 4'd9);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("zero_valid", txn_valid_o, 0);
        end
        check("zero_state", state_o, 2'd0);
        check("zero_meta", 64'(meta_cnt - m0), 0);
        expect_txn(64'h600, 1, 1, 10, 1'b1, 1'b1);
        push(1, 64'h600, 16'd1, 2'd0, 1'b0, 64'h0, 4'd10);
        drain("zero_next_drain");

        // reset in the middle of FRAG with a full FIFO
        txn_ready_i = 1'b0;
        push(0, 64'h3000, 16'd8, 2'd0, 1'b0, 64'h0, 4'd6);
        push(1, 64'h4000, 16'd1, 2'd0, 1'b0, 64'h0, 4'd11);
        push(1, 64'h4100, 16'd1, 2'd0, 1'b0, 64'h0, 4'd12);
        check("mid_state", state_o, 2'd3);
        check("mid_full_ready", req_ready_o[1], 0);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_valid", txn_valid_o, 0);
        check("mid_rst_addr", txn_addr_o, 0);
        check("mid_rst_bytes", 64'(txn_bytes_o), 0);
        check("mid_rst_ready", req_ready_o, 0);
        check("mid_rst_state", state_o, 0);
        exp_q.delete();
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        check("mid_post_ready", req_ready_o, 2'b11);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_post_valid", txn_valid_o, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
